seg7_scan_driver: RTL and testbench

Time-multiplexed, parametrised seven-segment driver for the digital clock's display board. It latches a packed vector of DIGITS hex nibbles with per-digit blank and decimal-point bits, and refreshes one digit at a time through active-low anode and segment outputs. Optional leading-zero blanking is supported. Updates are tear-free: new data is applied only at frame boundaries. It sits between the timekeeping datapath and the board pins and replaces per-digit combinational decoders.

---
 rtl/seg7_scan_driver.sv | 175 +++++++++++++++++
 tb/tb_seg7_scan_driver.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed active-low seven-segment driver with tear-free double-buffered data.
// Latency: a load shows from the frame after the next wrap; outputs are registered and change only on scan ticks.
// Backpressure: none; load is a one-cycle strobe that is always accepted into the pending bank.
//
// Ports:
//   clk, reset                  system clock, asynchronous active-high reset
//   digits_in[4*DIGITS-1:0]     hex nibbles, digit 0 rightmost
//   blank_in/dp_in/blink_mask   per-digit force-dark, decimal point, blink participation
//   lz_en                       leading-zero blanking enable
//   load                        captures all inputs above into the pending bank
//   an[DIGITS-1:0], seg7[6:0]   active-low anodes and segments (bit0=a .. bit6=g)
//   dp_n                        active-low decimal point
//   frame_done                  one-cycle pulse after each frame wrap
// Optional feature: define SEG7_BLINK_EN to build the frame counter and blink phase.
module seg7_scan_driver #(
  parameter int DIGITS    = 4,
  parameter int CLK_DIV   = 50000,
  parameter int BLINK_DIV = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*DIGITS-1:0]   digits_in,
  input  logic [DIGITS-1:0]     blank_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blink_mask,
  input  logic                  lz_en,
  input  logic                  load,
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            seg7,
  output logic                  dp_n,
  output logic                  frame_done
);

  localparam int CW = $clog2(CLK_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [CW-1:0]       cnt;
  logic [IW-1:0]       idx;
  logic [4*DIGITS-1:0] pend_dig,   act_dig;
  logic [DIGITS-1:0]   pend_blank, act_blank;
  logic [DIGITS-1:0]   pend_dp,    act_dp;
  logic [DIGITS-1:0]   pend_mask,  act_mask;
  logic                pend_lz,    act_lz;

  logic                tick, wrap;
  logic [IW-1:0]       nidx;
  logic [4*DIGITS-1:0] sel_dig;
  logic [DIGITS-1:0]   sel_blank, sel_dp;
  logic                sel_lz;
  logic [DIGITS-1:0]   zrun;
  logic                zacc;
  logic [3:0]          nib;
  logic                suppress, blink_dark, dark;
  logic [DIGITS-1:0]   an_nxt;
  logic [6:0]          seg_nxt;
  logic                dp_nxt;

  function automatic logic [6:0] decode(input logic [3:0] n);
    case (n)
      4'h0: decode = 7'h40;  4'h1: decode = 7'h79;
      4'h2: decode = 7'h24;  4'h3: decode = 7'h30;
      4'h4: decode = 7'h19;  4'h5: decode = 7'h12;
      4'h6: decode = 7'h02;  4'h7: decode = 7'h78;
      4'h8: decode = 7'h00;  4'h9: decode = 7'h18;
      4'hA: decode = 7'h08;  4'hB: decode = 7'h03;
      4'hC: decode = 7'h46;  4'hD: decode = 7'h21;
      4'hE: decode = 7'h06;  default: decode = 7'h0E;
    endcase
  endfunction

  always_comb begin
    tick = (cnt == CW'(CLK_DIV - 1));
    wrap = tick && (idx == IW'(DIGITS - 1));
    nidx = wrap ? '0 : idx + IW'(1);
    // On the wrap edge the active bank is loaded from pending, so digit 0 of
    // the new frame must be decoded from pending to show the new data at once.
    sel_dig   = wrap ? pend_dig   : act_dig;
    sel_blank = wrap ? pend_blank : act_blank;
    sel_dp    = wrap ? pend_dp    : act_dp;
    sel_lz    = wrap ? pend_lz    : act_lz;
    // zrun[i]: every nibble from the top digit down to i is zero.
    zacc = 1'b1;
    zrun = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zacc    = zacc && (sel_dig[4*i +: 4] == 4'h0);
      zrun[i] = zacc;
    end
    nib      = sel_dig[{nidx, 2'b00} +: 4];
    suppress = sel_lz && (nidx != '0) && zrun[nidx];
  end

`ifdef SEG7_BLINK_EN
  localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [FW-1:0]     fcnt;
  logic              phase, phase_nxt, fterm;
  logic [DIGITS-1:0] sel_mask;

  always_comb begin
    fterm     = (fcnt == FW'(BLINK_DIV - 1));
    phase_nxt = fterm ? ~phase : phase;
    sel_mask  = wrap ? pend_mask : act_mask;
    // The phase toggles on the wrap edge, so the new frame uses the new phase.
    blink_dark = (wrap ? phase_nxt : phase) && sel_mask[nidx];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fcnt  <= '0;
      phase <= 1'b0;
    end else if (wrap) begin
      fcnt  <= fterm ? '0 : fcnt + FW'(1);
      phase <= phase_nxt;
    end
  end
`else
  // Blink mask is still captured so the register map is identical in both builds.
  logic unused_blink;
  assign unused_blink = ^{act_mask, (BLINK_DIV > 0)};
  assign blink_dark   = 1'b0;
`endif

  always_comb begin
    dark    = sel_blank[nidx] || suppress || blink_dark;
    an_nxt  = dark ? '1 : ~(DIGITS'(1) << nidx);
    seg_nxt = dark ? 7'h7F : decode(nib);
    dp_nxt  = dark ? 1'b1 : ~sel_dp[nidx];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt        <= '0;
      idx        <= '0;
      pend_dig   <= '0;
      pend_blank <= '1;
      pend_dp    <= '0;
      pend_mask  <= '0;
      pend_lz    <= 1'b0;
      act_dig    <= '0;
      act_blank  <= '1;
      act_dp     <= '0;
      act_mask   <= '0;
      act_lz     <= 1'b0;
      an         <= '1;
      seg7       <= 7'h7F;
      dp_n       <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      cnt        <= tick ? '0 : cnt + CW'(1);
      frame_done <= wrap;
      if (tick) begin
        idx  <= nidx;
        an   <= an_nxt;
        seg7 <= seg_nxt;
        dp_n <= dp_nxt;
      end
      // Active takes the old pending even when a load lands on the wrap edge.
      if (wrap) begin
        act_dig   <= pend_dig;
        act_blank <= pend_blank;
        act_dp    <= pend_dp;
        act_mask  <= pend_mask;
        act_lz    <= pend_lz;
      end
      if (load) begin
        pend_dig   <= digits_in;
        pend_blank <= blank_in;
        pend_dp    <= dp_in;
        pend_mask  <= blink_mask;
        pend_lz    <= lz_en;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver with DIGITS=4, CLK_DIV=4, BLINK_DIV=2.
// Expected per-digit outputs are pushed to a queue when data is loaded and
// popped while the bench samples each 4-cycle dwell of a 16-cycle frame.
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] digits_in = '0;
  logic [3:0]  blank_in = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  blink_mask = '0;
  logic        lz_en = 1'b0;
  logic        load = 1'b0;
  logic [3:0]  an;
  logic [6:0]  seg7;
  logic        dp_n;
  logic        frame_done;

  seg7_scan_driver #(.DIGITS(4), .CLK_DIV(4), .BLINK_DIV(2)) dut (
    .clk(clk), .reset(reset), .digits_in(digits_in), .blank_in(blank_in),
    .dp_in(dp_in), .blink_mask(blink_mask), .lz_en(lz_en), .load(load),
    .an(an), .seg7(seg7), .dp_n(dp_n), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dpn;
  } exp_t;

  exp_t       q[$];
  int         total = 0;
  int         bad = 0;
  int         nwrap;
  int         n;
  logic [6:0] segtab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Wraps seen since reset; at the negedge where frame_done is high after
  // wrap k this holds k-1.
  always @(posedge clk or posedge reset) begin
    if (reset) nwrap <= 0;
    else if (frame_done) nwrap <= nwrap + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Blink phase of the frame that has just started (after wrap k: (k/2)%2).
  function automatic bit phase_now();
    bit ph;
    ph = bit'(((nwrap + 1) / 2) % 2);
`ifdef SEG7_BLINK_EN
    return ph;
`else
    return 1'b0 & ph;
`endif
  endfunction

  task automatic push_frame(input logic [15:0] d, input logic [3:0] b, input logic [3:0] dp,
                            input logic [3:0] m, input logic lz, input bit ph);
    exp_t e;
    bit   nz, drk;
    logic [3:0] nb;
    for (int i = 0; i < 4; i++) begin
      nz = 1'b0;
      for (int j = i; j < 4; j++) if (d[4*j +: 4] != 4'h0) nz = 1'b1;
      drk = b[i] || (lz && (i > 0) && !nz) || (ph && m[i]);
      nb  = d[4*i +: 4];
      if (drk) e = '{an: 4'hF, seg: 7'h7F, dpn: 1'b1};
      else     e = '{an: ~(4'b0001 << i), seg: segtab[nb], dpn: ~dp[i]};
      q.push_back(e);
    end
  endtask

  task automatic wait_wrap(output int cyc);
    bit seen;
    seen = 1'b0;
    cyc  = 0;
    while (!seen && cyc < 200) begin
      @(negedge clk);
      cyc++;
      seen = frame_done;
    end
    total++;
    assert (seen) else begin
      bad++;
      $error("FAIL wait_wrap got=timeout exp=frame_done");
    end
  endtask

  // Entered at the negedge where frame_done is high; samples all 16 cycles.
  task automatic check_frame(input string tag);
    exp_t e;
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("%s qsize", tag), (q.size() != 0), 1);
      if (q.size() == 0) return;
      e = q.pop_front();
      for (int s = 0; s < 4; s++) begin
        if (d > 0 || s > 0) @(negedge clk);
        chk($sformatf("%s d%0d c%0d out", tag, d, s), {an, seg7, dp_n}, e);
        chk($sformatf("%s d%0d c%0d fd", tag, d, s), frame_done, (d == 0 && s == 0));
      end
    end
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] b, input logic [3:0] dp,
                         input logic [3:0] m, input logic lz);
    digits_in  = d;
    blank_in   = b;
    dp_in      = dp;
    blink_mask = m;
    lz_en      = lz;
    load       = 1'b1;
    @(negedge clk);
    load       = 1'b0;
  endtask

  // Load mid-frame, then stop at the start of the frame that shows it.
  task automatic load_next(input logic [15:0] d, input logic [3:0] b, input logic [3:0] dp,
                           input logic [3:0] m, input logic lz);
    int c;
    wait_wrap(c);
    do_load(d, b, dp, m, lz);
    wait_wrap(c);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst an", an, 4'hF);
    chk("rst seg7", seg7, 7'h7F);
    chk("rst dp_n", dp_n, 1'b1);
    chk("rst frame_done", frame_done, 1'b0);
    reset = 1'b0;

    wait_wrap(n);
    chk("first wrap dwell", n, 16);
    push_frame(16'h0000, 4'hF, 4'h0, 4'h0, 1'b0, 1'b0);
    check_frame("dark0");

    load_next(16'h1234, 4'h0, 4'b0100, 4'h0, 1'b0);
    push_frame(16'h1234, 4'h0, 4'b0100, 4'h0, 1'b0, phase_now());
    check_frame("hex1234");

    load_next(16'h0070, 4'h0, 4'h0, 4'h0, 1'b1);
    push_frame(16'h0070, 4'h0, 4'h0, 4'h0, 1'b1, phase_now());
    check_frame("lzb0070");

    load_next(16'h0000, 4'h0, 4'h0, 4'h0, 1'b1);
    push_frame(16'h0000, 4'h0, 4'h0, 4'h0, 1'b1, phase_now());
    check_frame("lzb0000");

    // Positioned one cycle before a wrap: the load lands on the wrap edge.
    do_load(16'hABCD, 4'h0, 4'h0, 4'h0, 1'b0);
    push_frame(16'h0000, 4'h0, 4'h0, 4'h0, 1'b1, phase_now());
    check_frame("wrapold");
    wait_wrap(n);
    push_frame(16'hABCD, 4'h0, 4'h0, 4'h0, 1'b0, phase_now());
    check_frame("wrapnew");

    load_next(16'h5678, 4'h0, 4'h0, 4'b0011, 1'b0);
    for (int f = 0; f < 4; f++) begin
      if (f > 0) wait_wrap(n);
      push_frame(16'h5678, 4'h0, 4'h0, 4'b0011, 1'b0, phase_now());
      check_frame($sformatf("blink f%0d", f));
    end

    // Reset while digit 2 is lit.
    wait_wrap(n);
    repeat (8) @(negedge clk);
    chk("pre-reset an", an, 4'hB);
    chk("pre-reset seg7", seg7, 7'h02);
    reset = 1'b1;
    #1;
    chk("async rst an", an, 4'hF);
    chk("async rst seg7", seg7, 7'h7F);
    chk("async rst dp_n", dp_n, 1'b1);
    chk("async rst frame_done", frame_done, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    wait_wrap(n);
    chk("post-reset dwell", n, 16);
    push_frame(16'h0000, 4'hF, 4'h0, 4'h0, 1'b0, 1'b0);
    check_frame("dark after reset");

    load_next(16'h1234, 4'h0, 4'b0100, 4'h0, 1'b0);
    push_frame(16'h1234, 4'h0, 4'b0100, 4'h0, 1'b0, phase_now());
    check_frame("reload");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
